// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Imported by seq_adder and digit_adder.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple of one-bit full adders.
// Purely combinational; one digit of the serial add.
module digit_adder
  import seq_adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i])
                    | (w_c[i] & (x[i] ^ y[i]));
  end

  assign co = w_c[DIGIT];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock,
// valid/ready on both sides, overflow and zero flags.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_w(NDIG);

  if ((WIDTH % DIGIT) != 0) begin : g_chk_mul
    $error("seq_adder: WIDTH must be a multiple of DIGIT");
  end
  if (DIGIT < 1 || DIGIT > WIDTH) begin : g_chk_rng
    $error("seq_adder: DIGIT out of range");
  end

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sa;
  logic             r_sb;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_acc;
  logic             w_hs;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_beff;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_nsum;

  assign w_acc  = in_valid && w_in_ready;
  assign w_hs   = w_out_valid && out_ready;
  assign w_last = (r_cnt == CW'(NDIG - 1));
  assign w_beff = sub ? ~b : b;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        if (w_hs) w_next = w_acc ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: w_in_ready = 1'b1;
      RUN:  w_in_ready = 1'b0;
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready;
      end
      default: w_in_ready = 1'b0;
    endcase
  end

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_dig (
    .x  (r_a[DIGIT-1:0]),
    .y  (r_b[DIGIT-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // New digit enters at the top; after NDIG shifts
  // digit 0 has reached the LSB position.
  assign w_nsum = (r_sum >> DIGIT)
                | (WIDTH'(w_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_acc) begin
      r_a     <= a;
      r_b     <= w_beff;
      r_sa    <= a[WIDTH-1];
      r_sb    <= w_beff[WIDTH-1];
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= w_nsum;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= (r_sa == r_sb)
               && (w_nsum[WIDTH-1] != r_sa);
        r_zero <= (w_nsum == '0);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: 32/4 table plus 8/8 and 8/1
// instances run in lockstep on identical operands.
module tb_seq_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv, ir, ov, ordy;
  logic [31:0] a, b, s;
  logic        ci, sb, co, vf, z;

  seq_adder #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .a(a), .b(b), .cin(ci), .sub(sb),
    .out_valid(ov), .out_ready(ordy),
    .sum(s), .cout(co), .overflow(vf), .zero(z)
  );

  logic       iv8, ordy8;
  logic [7:0] a8, b8;
  logic       ir8a, ov8a, co8a, vf8a, z8a;
  logic       ir8b, ov8b, co8b, vf8b, z8b;
  logic [7:0] s8a, s8b;

  seq_adder #(.WIDTH(8), .DIGIT(8)) dut8a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8a),
    .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
    .out_valid(ov8a), .out_ready(ordy8),
    .sum(s8a), .cout(co8a), .overflow(vf8a), .zero(z8a)
  );

  seq_adder #(.WIDTH(8), .DIGIT(1)) dut8b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8b),
    .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
    .out_valid(ov8b), .out_ready(ordy8),
    .sum(s8b), .cout(co8b), .overflow(vf8b), .zero(z8b)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t tbl[8];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!ir && g < 20) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run32(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    wait_ready();
    a = v.a; b = v.b; ci = v.cin; sb = v.sub; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    // Scramble operands: they must be ignored while running.
    a = $urandom; b = $urandom; ci = 1'b1; sb = ~v.sub;
    wait_out(lat);
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'd8);
    chk($sformatf("v%0d sum", idx), 64'(s), 64'(v.s));
    chk($sformatf("v%0d cout", idx), 64'(co), 64'(v.co));
    chk($sformatf("v%0d ovf", idx), 64'(vf), 64'(v.ov));
    chk($sformatf("v%0d zero", idx), 64'(z), 64'(v.z));
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  initial begin
    int lat, la, lb;
    logic [7:0] sa, sbv;
    logic [2:0] fa, fb;

    tbl[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
               32'h0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'd5, 32'd7, 1'b0, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'd7, 32'd7, 1'b0, 1'b1,
               32'h0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
               32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h1, 1'b0, 1'b1,
               32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'd100, 32'd23, 1'b0, 1'b0,
               32'd123, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
               32'h2345_678A, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'd10, 32'd3, 1'b1, 1'b1,
               32'd7, 1'b1, 1'b0, 1'b0};

    iv = 0; ordy = 0; a = 0; b = 0; ci = 0; sb = 0;
    iv8 = 0; ordy8 = 1'b1; a8 = 0; b8 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst out_valid", 64'(ov), 64'd0);
    chk("rst sum", 64'(s), 64'd0);
    chk("rst flags", 64'({co, vf, z}), 64'd0);
    chk("rst in_ready", 64'(ir), 64'd1);

    for (int i = 0; i < 8; i++) run32(tbl[i], i);

    // Backpressure then back-to-back accept on the handshake edge.
    @(negedge clk);
    a = 32'd1; b = 32'd2; ci = 0; sb = 0; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    wait_out(lat);
    chk("bp latency", 64'(lat), 64'd8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d", k),
          64'({ov, ir, s}), 64'({1'b1, 1'b0, 32'd3}));
    end
    a = 32'h1234_5678; b = 32'h1111_1111;
    ci = 0; sb = 0; iv = 1'b1; ordy = 1'b1;
    #1;
    chk("b2b in_ready", 64'(ir), 64'd1);
    @(posedge clk); #1;
    iv = 1'b0; ordy = 1'b0; a = 32'hDEAD_BEEF;
    chk("b2b no idle", 64'({ov, ir}), 64'd0);
    wait_out(lat);
    chk("b2b latency", 64'(lat), 64'd8);
    chk("b2b sum", 64'(s), 64'h2345_6789);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("b2b release", 64'({ov, ir}), 64'b01);

    // Reset mid-run after three digits.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    chk("midrst out", 64'({ov, s}), 64'd0);
    chk("midrst ready", 64'(ir), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    run32(tbl[5], 100);

    // 8-bit, whole-word and bit-serial, same operands.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; iv8 = 1'b1;
    chk("w8 ready", 64'({ir8a, ir8b}), 64'b11);
    @(posedge clk); #1;
    iv8 = 1'b0;
    la = 0; lb = 0; sa = 8'hAA; sbv = 8'hAA; fa = 0; fb = 0;
    for (int c = 1; c <= 12; c++) begin
      if (ov8a && la == 0) begin
        la = c - 1; sa = s8a; fa = {co8a, vf8a, z8a};
      end
      if (ov8b && lb == 0) begin
        lb = c - 1; sbv = s8b; fb = {co8b, vf8b, z8b};
      end
      @(posedge clk); #1;
    end
    chk("d8 latency", 64'(la), 64'd1);
    chk("d8 sum", 64'(sa), 64'h00);
    chk("d8 flags", 64'(fa), 64'b111);
    chk("d1 latency", 64'(lb), 64'd8);
    chk("d1 sum", 64'(sbv), 64'h00);
    chk("d1 flags", 64'(fb), 64'b111);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
